// File: rtl/mic1_pkg.sv
// Shared types, field positions and the microinstruction decoder for the
// MIC-1 microsequencer.
package mic1_pkg;

  localparam int unsigned MPC_W = 9;
  localparam int unsigned MIR_W = 36;
  localparam int unsigned MBR_W = 8;
  localparam int unsigned C_W   = 9;
  localparam int unsigned B_W   = 4;

  localparam int unsigned NA_LSB    = 27;
  localparam int unsigned JMPC_BIT  = 26;
  localparam int unsigned JAMN_BIT  = 25;
  localparam int unsigned JAMZ_BIT  = 24;
  localparam int unsigned SLL8_BIT  = 23;
  localparam int unsigned SRA1_BIT  = 22;
  localparam int unsigned F0_BIT    = 21;
  localparam int unsigned F1_BIT    = 20;
  localparam int unsigned ENA_BIT   = 19;
  localparam int unsigned ENB_BIT   = 18;
  localparam int unsigned INVA_BIT  = 17;
  localparam int unsigned INC_BIT   = 16;
  localparam int unsigned C_LSB     = 7;
  localparam int unsigned WRITE_BIT = 6;
  localparam int unsigned READ_BIT  = 5;
  localparam int unsigned FETCH_BIT = 4;
  localparam int unsigned B_LSB     = 0;

  typedef struct packed {
    logic [MPC_W-1:0] next_address;
    logic             jmpc;
    logic             jamn;
    logic             jamz;
    logic             sll8;
    logic             sra1;
    logic             f0;
    logic             f1;
    logic             ena;
    logic             enb;
    logic             inva;
    logic             inc;
    logic [C_W-1:0]   c;
    logic             mem_write;
    logic             mem_read;
    logic             mem_fetch;
    logic [B_W-1:0]   b;
  } mir_t;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  // Split a raw control-store word into its named fields.
  function automatic mir_t decode_mir(input logic [MIR_W-1:0] w);
    mir_t m;
    m.next_address = w[NA_LSB +: MPC_W];
    m.jmpc         = w[JMPC_BIT];
    m.jamn         = w[JAMN_BIT];
    m.jamz         = w[JAMZ_BIT];
    m.sll8         = w[SLL8_BIT];
    m.sra1         = w[SRA1_BIT];
    m.f0           = w[F0_BIT];
    m.f1           = w[F1_BIT];
    m.ena          = w[ENA_BIT];
    m.enb          = w[ENB_BIT];
    m.inva         = w[INVA_BIT];
    m.inc          = w[INC_BIT];
    m.c            = w[C_LSB +: C_W];
    m.mem_write    = w[WRITE_BIT];
    m.mem_read     = w[READ_BIT];
    m.mem_fetch    = w[FETCH_BIT];
    m.b            = w[B_LSB +: B_W];
    return m;
  endfunction

endpackage

// File: rtl/mic1_next_addr.sv
// Next-microaddress former: NEXT_ADDRESS with MBR OR-ed into the low byte on
// JMPC and bit 8 forced by a taken JAMN/JAMZ.
module mic1_next_addr
  import mic1_pkg::*;
(
  input  mir_t             mir,
  input  logic             n_in,
  input  logic             z_in,
  input  logic [MBR_W-1:0] mbr_in,
  output logic [MPC_W-1:0] addr
);

  logic unused_mir_bits;
  assign unused_mir_bits = ^mir;

  always_comb begin
    addr = mir.next_address;
    if (mir.jmpc) begin
      addr[MBR_W-1:0] = addr[MBR_W-1:0] | mbr_in;
    end
    if ((mir.jamn && n_in) || (mir.jamz && z_in)) begin
      addr[MPC_W-1] = 1'b1;
    end
  end

endmodule

// File: rtl/mic1_microsequencer.sv
// MIC-1 microprogram sequencer: MPC, control-store addressing, output gating,
// flag latching, stall handling and self-loop halt detection.
module mic1_microsequencer
  import mic1_pkg::*;
#(
  parameter logic [MPC_W-1:0] RESET_ADDR = 9'h000
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [MPC_W-1:0] CS_ADDR,
  input  logic [MIR_W-1:0] CS_DATA,
  input  logic             N_IN,
  input  logic             Z_IN,
  input  logic [MBR_W-1:0] MBR_IN,
  input  logic             STALL,
  output logic             F0,
  output logic             F1,
  output logic             ENA,
  output logic             ENB,
  output logic             INVA,
  output logic             INC,
  output logic             SLL8,
  output logic             SRA1,
  output logic [C_W-1:0]   C_EN,
  output logic [B_W-1:0]   B_SEL,
  output logic             MEM_WRITE,
  output logic             MEM_READ,
  output logic             MEM_FETCH,
  output logic             N_Q,
  output logic             Z_Q,
  output logic             HALTED
);

  seq_state_t       state_q, state_d;
  logic [MPC_W-1:0] mpc_q, mpc_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic [MPC_W-1:0] next_addr;
  logic [MPC_W-1:0] cs_addr_c;
  logic             exec_c;
  logic             halt_hit_c;
  mir_t             mir;

  assign mir = decode_mir(CS_DATA);

  mic1_next_addr u_next_addr (
    .mir    (mir),
    .n_in   (N_IN),
    .z_in   (Z_IN),
    .mbr_in (MBR_IN),
    .addr   (next_addr)
  );

  // A word that jumps to its own address with no JAM bits can never leave.
  assign halt_hit_c = !mir.jmpc && !mir.jamn && !mir.jamz &&
                      (mir.next_address == mpc_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BOOT;
      mpc_q   <= RESET_ADDR;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      mpc_q   <= mpc_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mpc_d     = mpc_q;
    n_d       = n_q;
    z_d       = z_q;
    exec_c    = 1'b0;
    cs_addr_c = mpc_q;
    unique case (state_q)
      BOOT: begin
        cs_addr_c = RESET_ADDR;
        mpc_d     = RESET_ADDR;
        state_d   = RUN;
      end
      RUN: begin
        if (!STALL) begin
          exec_c    = 1'b1;
          cs_addr_c = next_addr;
          mpc_d     = next_addr;
          n_d       = N_IN;
          z_d       = Z_IN;
          if (halt_hit_c) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
    // Reset forces the boot address onto the store this very cycle.
    if (RST) begin
      cs_addr_c = RESET_ADDR;
      exec_c    = 1'b0;
    end
  end

  // Datapath controls are live only on an executing cycle.
  always_comb begin
    SLL8      = 1'b0;
    SRA1      = 1'b0;
    F0        = 1'b0;
    F1        = 1'b0;
    ENA       = 1'b0;
    ENB       = 1'b0;
    INVA      = 1'b0;
    INC       = 1'b0;
    C_EN      = '0;
    B_SEL     = '0;
    MEM_WRITE = 1'b0;
    MEM_READ  = 1'b0;
    MEM_FETCH = 1'b0;
    if (exec_c) begin
      SLL8      = mir.sll8;
      SRA1      = mir.sra1;
      F0        = mir.f0;
      F1        = mir.f1;
      ENA       = mir.ena;
      ENB       = mir.enb;
      INVA      = mir.inva;
      INC       = mir.inc;
      C_EN      = mir.c;
      B_SEL     = mir.b;
      MEM_WRITE = mir.mem_write;
      MEM_READ  = mir.mem_read;
      MEM_FETCH = mir.mem_fetch;
    end
  end

  assign CS_ADDR = cs_addr_c;
  assign N_Q     = n_q;
  assign Z_Q     = z_q;
  assign HALTED  = (state_q == HALT);

endmodule
